// File: rtl/mips_exc_ctrl_if.sv
// mips_exc_ctrl_if: EX-stage, CP0 and pipeline-control signals of the exception sequencer
interface mips_exc_ctrl_if #(parameter int ADDR_W = 32);
   logic              EX_VALID;
   logic [ADDR_W-1:0] EX_PC;
   logic              EX_BD;
   logic              EX_ADEL_I, EX_RI, EX_SYSCALL, EX_BREAK, EX_OV, EX_ADEL_D, EX_ADES_D;
   logic              EX_ERET;
   logic              EXC_OCCUR;
   logic [ADDR_W-1:0] EXC_NPC;
   logic              EXC_SET, EXC_ACK, EXC_CLR;
   logic [3:0]        EXC_CODE;
   logic [ADDR_W-1:0] EXC_EPC;
   logic              EXC_BD;
   logic              STALL, FLUSH, REDIRECT;
   logic [ADDR_W-1:0] REDIRECT_PC;
   logic              EXC_HANG;
   modport master (
      output EX_VALID, EX_PC, EX_BD, EX_ADEL_I, EX_RI, EX_SYSCALL, EX_BREAK, EX_OV,
             EX_ADEL_D, EX_ADES_D, EX_ERET, EXC_OCCUR, EXC_NPC,
      input  EXC_SET, EXC_ACK, EXC_CLR, EXC_CODE, EXC_EPC, EXC_BD, STALL, FLUSH,
             REDIRECT, REDIRECT_PC, EXC_HANG
   );
   modport slave (
      input  EX_VALID, EX_PC, EX_BD, EX_ADEL_I, EX_RI, EX_SYSCALL, EX_BREAK, EX_OV,
             EX_ADEL_D, EX_ADES_D, EX_ERET, EXC_OCCUR, EXC_NPC,
      output EXC_SET, EXC_ACK, EXC_CLR, EXC_CODE, EXC_EPC, EXC_BD, STALL, FLUSH,
             REDIRECT, REDIRECT_PC, EXC_HANG
   );
endinterface

// File: rtl/mips_exc_ctrl.sv
// mips_exc_ctrl: sequences sync exceptions, ERET and CP0 interrupts through the CP0 request port
// Define EXC_WDT_EN to add the WAIT-state watchdog that raises the sticky EXC_HANG flag.
module mips_exc_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int WDT_CYC = 16
) (
   input logic           CLK,
   input logic           RST_X,
   mips_exc_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, ACK, CLR, RET} state_t;
   state_t state_q, state_d;
   logic [3:0] code_q, code_d, exc_code;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic bd_q, bd_d, hang_q, hang_d;
   logic any_exc, live, take_exc, take_eret, take_int, flush, wdt_hit;
`ifdef EXC_WDT_EN
   localparam int CW = $clog2(WDT_CYC + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   // counter restarts on every entry into WAIT
   assign cnt_d   = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
   assign wdt_hit = state_q == WAIT && !bus.EXC_OCCUR && cnt_q == CW'(WDT_CYC - 1);
   always_ff @(posedge CLK)
      cnt_q <= !RST_X ? '0 : cnt_d;
`else
   assign wdt_hit = 1'b0;
`endif
   always_comb begin
      any_exc   = bus.EX_ADEL_I | bus.EX_RI | bus.EX_SYSCALL | bus.EX_BREAK |
                  bus.EX_OV | bus.EX_ADEL_D | bus.EX_ADES_D;
      exc_code  = bus.EX_ADEL_I ? 4'd4 : bus.EX_RI ? 4'd10 : bus.EX_SYSCALL ? 4'd8 :
                  bus.EX_BREAK ? 4'd9 : bus.EX_OV ? 4'd12 : bus.EX_ADEL_D ? 4'd4 : 4'd5;
      live      = RST_X && state_q == IDLE && bus.EX_VALID;
      take_exc  = live && any_exc;
      take_eret = live && !any_exc && bus.EX_ERET;
      take_int  = live && !any_exc && !bus.EX_ERET && bus.EXC_OCCUR;
      flush     = take_exc || take_eret || take_int;
      state_d   = state_q;
      code_d    = code_q;
      epc_d     = epc_q;
      bd_d      = bd_q;
      hang_d    = hang_q | wdt_hit;
      case (state_q)
         IDLE:    state_d = take_exc ? REQ : take_int ? WAIT : take_eret ? CLR : IDLE;
         REQ:     state_d = WAIT;
         WAIT:    state_d = bus.EXC_OCCUR ? ACK : wdt_hit ? IDLE : WAIT;
         ACK:     state_d = IDLE;
         CLR:     state_d = RET;
         RET:     state_d = bus.EXC_OCCUR ? ACK : IDLE;
         default: state_d = IDLE;
      endcase
      // ERET leaves the latched EPC alone so a pre-empted clear re-enters the same handler
      if (take_exc || take_int) begin
         code_d = take_exc ? exc_code : 4'd0;
         epc_d  = bus.EX_BD ? bus.EX_PC - ADDR_W'(4) : bus.EX_PC;
         bd_d   = bus.EX_BD;
      end
   end
   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state_q <= IDLE;
         code_q  <= '0;
         epc_q   <= '0;
         bd_q    <= 1'b0;
         hang_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         epc_q   <= epc_d;
         bd_q    <= bd_d;
         hang_q  <= hang_d;
      end
   end
   assign bus.FLUSH       = flush;
   assign bus.STALL       = flush || state_q != IDLE;
   assign bus.EXC_SET     = state_q == REQ;
   assign bus.EXC_ACK     = state_q == ACK;
   assign bus.EXC_CLR     = state_q == CLR;
   assign bus.REDIRECT    = state_q == ACK || (state_q == RET && !bus.EXC_OCCUR);
   assign bus.REDIRECT_PC = bus.REDIRECT ? bus.EXC_NPC : '0;
   assign bus.EXC_CODE    = code_q;
   assign bus.EXC_EPC     = epc_q;
   assign bus.EXC_BD      = bd_q;
   assign bus.EXC_HANG    = hang_q;
endmodule

// File: doc/mips_exc_ctrl.md
# mips_exc_ctrl

Pipeline-side exception sequencer for the MipsCore. Collects synchronous exception flags and ERET from the EX stage, then drives the CP0 exception request port (EXC_SET/EXC_ACK/EXC_CLR with code, EPC and BD). It consumes the CP0 responses EXC_OCCUR and EXC_NPC, so timer interrupts raised inside CP0 are also handled here. Toward the pipeline it produces stall, flush and PC-redirect.

## Interface
- ADDR_W, 32, address width of EX_PC / EXC_EPC / EXC_NPC / REDIRECT_PC
- WDT_CYC, 16, watchdog limit in cycles (used only with EXC_WDT_EN)

Ports:
- CLK  in  1  clock; all state on rising edge
- RST_X  in  1  reset, synchronous, active-low
- EX_VALID  in  1  EX stage holds a live instruction
- EX_PC  in  ADDR_W  PC of EX instruction
- EX_BD  in  1  EX instruction sits in a branch delay slot
- EX_ADEL_I, EX_RI, EX_SYSCALL, EX_BREAK, EX_OV, EX_ADEL_D, EX_ADES_D  in  1 each  exception flags of EX instruction
- EX_ERET  in  1  EX instruction is ERET
- EXC_OCCUR  in  1  CP0 exception pending
- EXC_NPC  in  ADDR_W  CP0 handler entry / return address
- EXC_SET, EXC_ACK, EXC_CLR  out  1 each  CP0 request pulses
- EXC_CODE  out  4  cause code
- EXC_EPC  out  ADDR_W  restart address
- EXC_BD  out  1  delay-slot flag
- STALL  out  1  freeze IF/ID/EX
- FLUSH  out  1  kill IF/ID/EX contents (no writeback)
- REDIRECT  out  1  load PC from REDIRECT_PC
- REDIRECT_PC  out  ADDR_W  new PC
- EXC_HANG  out  1  sticky watchdog flag (EXC_WDT_EN only)

## Operation
- States: IDLE, REQ, WAIT, ACK, CLR, RET.
- Detection runs in IDLE only and requires EX_VALID=1. Priority runs ADEL_I(4) > RI(10) > SYSCALL(8) > BREAK(9) > OV(12) > ADEL_D(4) > ADES_D(5). An exception beats ERET, and ERET beats an interrupt.
- Sync exception in IDLE:
  - FLUSH=1 and STALL=1 combinationally in the same cycle.
  - Latch code, EPC = EX_BD ? EX_PC-4 : EX_PC (mod 2^ADDR_W), and BD = EX_BD.
  - Next state REQ.
- REQ: EXC_SET=1, STALL=1; next state WAIT.
- WAIT: STALL=1. When EXC_OCCUR=1, go to ACK.
- ACK:
  - EXC_ACK=1, REDIRECT=1, REDIRECT_PC=EXC_NPC, STALL=1.
  - EXC_EPC/EXC_BD stay stable, because CP0 samples them here.
  - Next state IDLE.
- Interrupt: in IDLE with EXC_OCCUR=1, EX_VALID=1, no exception flag and no ERET.
  - FLUSH=1 and STALL=1 combinationally.
  - Latch EPC/BD as above; code 0.
  - Go straight to WAIT; EXC_SET is not pulsed.
- Interrupt with EX_VALID=0: stay in IDLE with no stall; wait for a valid instruction.
- ERET in IDLE: FLUSH=1 and STALL=1; next state CLR.
- CLR: EXC_CLR=1, STALL=1; next state RET.
- RET, depending on EXC_OCCUR:
  - EXC_OCCUR=0: REDIRECT=1, REDIRECT_PC=EXC_NPC (the CP0 EPC); next state IDLE.
  - EXC_OCCUR=1 (CP0 interrupt pre-empted the clear): go to ACK. CP0 keeps its EPC because EXL is still set, so the handler is re-entered.
- EXC_EPC/EXC_CODE/EXC_BD are held from latch until the next latch; reset value 0.

## Timing
- Exception detected in cycle t:
  - FLUSH@t
  - EXC_SET@t+1
  - EXC_OCCUR seen@t+2
  - EXC_ACK+REDIRECT@t+3
  - IDLE, STALL=0@t+4
- Interrupt seen at t: FLUSH@t, WAIT@t+1, ACK+REDIRECT@t+2, IDLE@t+3.
- ERET at t: FLUSH@t, EXC_CLR@t+1, REDIRECT@t+2, IDLE@t+3.
- All outputs except FLUSH/STALL in IDLE are registered.
- Synchronous reset at any edge forces IDLE, clears latches, and drives every output 0. A sequence in flight is abandoned; CP0 is reset by the same RST_X.
- EXC_OCCUR=1 in ACK's following cycle is not re-taken. CP0 clears it on the ACK edge, so IDLE never sees a stale value.

## Configuration
- EXC_WDT_EN defined:
  - WAIT counts cycles.
  - If the count reaches WDT_CYC with EXC_OCCUR still 0, set EXC_HANG=1 (sticky until reset) and return to IDLE with no redirect.
  - The counter clears on entering WAIT.
- EXC_WDT_EN undefined: no counter; WAIT waits indefinitely; EXC_HANG tied 0.

## Test plan
- EX_VALID=1, EX_SYSCALL=1, EX_PC=0x400, EX_BD=0:
  - EXC_SET@t+1 with EXC_CODE=8, EXC_EPC=0x400, EXC_BD=0.
  - ACK@t+3 with REDIRECT_PC=0x100.
- EX_OV=1 and EX_RI=1 together, EX_PC=0x208, EX_BD=1 -> EXC_CODE=10, EXC_EPC=0x204, EXC_BD=1.
- CP0 timer raises EXC_OCCUR, EX_PC=0x330 -> no EXC_SET, EXC_EPC=0x330, EXC_ACK@t+2, REDIRECT_PC=0x100.
- EX_ERET=1 with CP0 EPC=0x404 -> EXC_CLR@t+1, REDIRECT_PC=0x404@t+2, STALL low@t+3.
- ERET with an interrupt firing on the EXC_CLR cycle -> RET goes to ACK, REDIRECT_PC=0x100, no second EXC_CLR.
- RST_X low during WAIT -> all outputs 0 next cycle, IDLE. With EXC_WDT_EN and EXC_OCCUR held 0, EXC_HANG=1 after 16 WAIT cycles.
